// File: rtl/zbt_pkg.sv
// Shared constants and encodings for the ZBT port arbiter: default widths,
// drain-mode FSM states and the per-cycle slot encoding.
package zbt_pkg;

   localparam int ADDR_W_DEF = 19;
   localparam int DATA_W_DEF = 36;

   localparam logic ST_NORMAL = 1'b0;
   localparam logic ST_DRAIN  = 1'b1;

   typedef enum logic {
      S_NORMAL = ST_NORMAL,
      S_DRAIN  = ST_DRAIN
   } arb_state_e;

   typedef enum logic [1:0] {
      SLOT_IDLE = 2'd0,
      SLOT_RD   = 2'd1,
      SLOT_WR   = 2'd2
   } slot_e;

endpackage

// File: rtl/zbt_port_arbiter_if.sv
// Bus bundle between the capture writer / display reader and the ZBT driver,
// as seen by the arbiter (slave) and by the surrounding logic (master).
interface zbt_port_arbiter_if #(
   parameter int ADDR_W = zbt_pkg::ADDR_W_DEF,
   parameter int DATA_W = zbt_pkg::DATA_W_DEF
);
   // rd_req is held with a stable rd_addr until rd_ack is seen in the same
   // cycle; wr_req is a one-cycle pulse with no backpressure.
   logic              wr_req;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_ack;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  wr_req, wr_addr, wr_data, rd_req, rd_addr, mem_rdata,
      output rd_ack, rd_valid, rd_data, mem_addr, mem_we, mem_wdata
   );

   modport master (
      output wr_req, wr_addr, wr_data, rd_req, rd_addr, mem_rdata,
      input  rd_ack, rd_valid, rd_data, mem_addr, mem_we, mem_wdata
   );
endinterface

// File: rtl/zbt_wr_fifo.sv
// Synchronous write buffer; push is accepted while full only when a pop
// happens in the same cycle.
module zbt_wr_fifo #(
   parameter int  WIDTH = 55,
   parameter int  DEPTH = 8,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
      end
   end
endmodule

// File: rtl/zbt_port_arbiter.sv
// Shares one ZBT port between buffered capture writes and prioritised display
// reads, with a hysteretic drain mode that protects the write buffer.
module zbt_port_arbiter
   import zbt_pkg::*;
#(
   parameter int  ADDR_W     = ADDR_W_DEF,
   parameter int  DATA_W     = DATA_W_DEF,
   parameter int  FIFO_DEPTH = 8,
   parameter int  HI_WATER   = 6,
   parameter int  LO_WATER   = 2,
   parameter int  READ_LAT   = 2,
   localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic              clk,
   input  logic              reset_n,
   zbt_port_arbiter_if.slave bus,
   output logic [CNT_W-1:0]  fifo_count,
   output logic              wr_overflow,
   output logic              mode_drain
);
   localparam int ENT_W = ADDR_W + DATA_W;

   arb_state_e        state;
   arb_state_e        state_nxt;
   slot_e             slot;
   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic              wr_drop;
   logic [ENT_W-1:0]  fifo_head;
   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] head_data;
   logic [CNT_W-1:0]  count_nxt;
   logic [READ_LAT:0] rd_pipe;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;

   zbt_wr_fifo #(.WIDTH(ENT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (fifo_push),
      .din     ({bus.wr_addr, bus.wr_data}),
      .pop     (fifo_pop),
      .dout    (fifo_head),
      .count   (fifo_count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign {head_addr, head_data} = fifo_head;

   always_comb begin
      slot = SLOT_IDLE;
      if (state == S_NORMAL) begin
         if (bus.rd_req)       slot = SLOT_RD;
         else if (!fifo_empty) slot = SLOT_WR;
      end else begin
         if (!fifo_empty)      slot = SLOT_WR;
         else if (bus.rd_req)  slot = SLOT_RD;
      end
   end

   assign fifo_pop  = (slot == SLOT_WR);
   assign fifo_push = bus.wr_req && (!fifo_full || fifo_pop);
   assign wr_drop   = bus.wr_req && fifo_full && !fifo_pop;
   // Mode is chosen on the fill level after this cycle's push/pop settle.
   assign count_nxt = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);

   always_comb begin
      state_nxt = state;
      case (state)
         S_NORMAL: if (count_nxt >= CNT_W'(HI_WATER)) state_nxt = S_DRAIN;
         S_DRAIN:  if (count_nxt <= CNT_W'(LO_WATER)) state_nxt = S_NORMAL;
         default:  state_nxt = S_NORMAL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) state <= S_NORMAL;
      else          state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rd_pipe     <= '0;
         wr_overflow <= 1'b0;
      end else begin
         rd_pipe <= {rd_pipe[READ_LAT-1:0], bus.rd_ack};
         if (wr_drop) wr_overflow <= 1'b1;
         case (slot)
            SLOT_WR: begin
               mem_we_q    <= 1'b1;
               mem_addr_q  <= head_addr;
               mem_wdata_q <= head_data;
            end
            SLOT_RD: begin
               mem_we_q   <= 1'b0;
               mem_addr_q <= bus.rd_addr;
            end
            default: mem_we_q <= 1'b0;
         endcase
      end
   end

   assign bus.rd_ack    = reset_n && (slot == SLOT_RD);
   assign bus.rd_valid  = rd_pipe[READ_LAT];
   assign bus.rd_data   = bus.mem_rdata;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign mode_drain    = (state == S_DRAIN);
endmodule

// File: tb/tb_zbt_port_arbiter.sv
// Bench for zbt_port_arbiter: directed vector table, drain/overflow sequences
// and randomized traffic against a queue-based reference model.
module tb_zbt_port_arbiter;
   localparam int AW = 19;
   localparam int DW = 36;
   localparam int CW = 4;
   localparam int NV = 10;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [CW-1:0] fifo_count;
   logic          wr_overflow;
   logic          mode_drain;

   always #5 clk = ~clk;

   zbt_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bif ();

   zbt_port_arbiter dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .bus         (bif),
      .fifo_count  (fifo_count),
      .wr_overflow (wr_overflow),
      .mode_drain  (mode_drain)
   );

   function automatic logic [DW-1:0] tag(input logic [AW-1:0] a);
      return {a[16:0], a} ^ 36'h5A5A5A5A5;
   endfunction

   // ZBT model: read word appears two cycles after the command is on mem_addr.
   logic [DW-1:0] mp1, mp2;
   always @(posedge clk) begin
      mp1 <= tag(bif.mem_addr);
      mp2 <= mp1;
   end
   assign bif.mem_rdata = mp2;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic          rst_n, wr, rd;
      logic [AW-1:0] wa, ra;
      logic [DW-1:0] wd;
      logic          e_ack, e_we, chk_wd, e_valid;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wd, e_rd;
      logic [CW-1:0] e_cnt;
   } vec_t;

   function automatic vec_t mk(input logic rst_n, wr, input logic [AW-1:0] wa,
                               input logic [DW-1:0] wd, input logic rd, input logic [AW-1:0] ra,
                               input logic e_ack, e_we, input logic [AW-1:0] e_addr,
                               input logic [DW-1:0] e_wd, input logic chk_wd,
                               input logic [CW-1:0] e_cnt, input logic e_valid,
                               input logic [DW-1:0] e_rd);
      vec_t v;
      v.rst_n = rst_n; v.wr = wr; v.wa = wa; v.wd = wd; v.rd = rd; v.ra = ra;
      v.e_ack = e_ack; v.e_we = e_we; v.e_addr = e_addr; v.e_wd = e_wd;
      v.chk_wd = chk_wd; v.e_cnt = e_cnt; v.e_valid = e_valid; v.e_rd = e_rd;
      return v;
   endfunction

   // Reference model: write buffer as a queue, reads as due-cycle records.
   typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
   typedef struct { int due; logic [AW-1:0] a; } rd_t;
   wr_t           wq[$];
   rd_t           rq[$];
   logic          m_drain, m_ovf, m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   int            cyc = 0;
   bit            nopop = 0;
   bit            log_en = 0;
   logic [AW-1:0] pushed[$];
   logic [AW-1:0] seen[$];
   int            n_ack = 0;
   int            n_valid = 0;

   task automatic model_reset();
      wq.delete(); rq.delete();
      m_drain = 0; m_ovf = 0; m_we = 0; m_addr = '0; m_wdata = '0;
   endtask

   task automatic model_check();
      logic e_ack, wslot, ev;
      int   c;
      e_ack = reset_n && bif.rd_req && (!m_drain || wq.size() == 0);
      wslot = reset_n && !e_ack && wq.size() != 0;
      chk("rd_ack", bif.rd_ack, e_ack);
      chk("fifo_count", fifo_count, wq.size());
      chk("mode_drain", mode_drain, m_drain);
      chk("wr_overflow", wr_overflow, m_ovf);
      chk("mem_we", bif.mem_we, m_we);
      chk("mem_addr", bif.mem_addr, m_addr);
      if (m_we) chk("mem_wdata", bif.mem_wdata, m_wdata);
      ev = rq.size() != 0 && rq[0].due == cyc;
      chk("rd_valid", bif.rd_valid, ev);
      if (ev) begin
         chk("rd_data", bif.rd_data, tag(rq[0].a));
         void'(rq.pop_front());
      end
      if (!reset_n) begin
         model_reset();
      end else begin
         if (wslot) begin
            m_we = 1; m_addr = wq[0].a; m_wdata = wq[0].d;
         end else begin
            m_we = 0;
            if (e_ack) m_addr = bif.rd_addr;
         end
         if (wslot && !nopop) void'(wq.pop_front());
         if (bif.wr_req) begin
            if (wq.size() < 8) wq.push_back('{bif.wr_addr, bif.wr_data});
            else m_ovf = 1;
         end
         c = wq.size();
         if (m_drain) begin
            if (c <= 2) m_drain = 0;
         end else if (c >= 6) begin
            m_drain = 1;
         end
         if (e_ack) rq.push_back('{cyc + 3, bif.rd_addr});
      end
      cyc++;
   endtask

   task automatic mstep(output logic ack);
      @(negedge clk);
      ack = bif.rd_ack;
      if (log_en) begin
         if (bif.mem_we)   seen.push_back(bif.mem_addr);
         if (bif.rd_ack)   n_ack++;
         if (bif.rd_valid) n_valid++;
      end
      model_check();
      @(posedge clk);
      #1;
   endtask

   task automatic hard_reset();
      reset_n = 0; bif.wr_req = 0; bif.rd_req = 0;
      @(posedge clk);
      #1;
      model_reset();
      reset_n = 1;
   endtask

   task automatic push_step(input logic [AW-1:0] a);
      logic ack;
      bif.wr_req = 1; bif.wr_addr = a; bif.wr_data = DW'($urandom());
      mstep(ack);
      bif.wr_req = 0;
   endtask

   task automatic rand_drive(input int n, input int k0, input bit rst_mid);
      logic        ack;
      logic [63:0] r;
      int          k;
      k = k0;
      for (int i = 0; i < n; i++) begin
         reset_n = !(rst_mid && i == n / 2);
         bif.wr_req = ($urandom_range(0, 3) == 0);
         if (bif.wr_req) begin
            r = {$urandom(), $urandom()};
            bif.wr_addr = AW'(k); bif.wr_data = r[DW-1:0];
            if (log_en) pushed.push_back(AW'(k));
            k++;
         end
         mstep(ack);
         if (ack || !bif.rd_req) begin
            bif.rd_req  = ($urandom_range(0, 1) == 1);
            bif.rd_addr = AW'($urandom());
         end
      end
      reset_n = 1;
      bif.wr_req = 0;
   endtask

   initial begin
      vec_t        vt[NV];
      logic        ack;
      logic [11:0] ackv;

      reset_n = 0; bif.wr_req = 1; bif.rd_req = 1;
      bif.wr_addr = '0; bif.wr_data = '0; bif.rd_addr = '0;
      @(posedge clk);
      #1;

      //         rst wr wa        wd             rd ra      ack we addr      wd             cw cnt v rdata
      vt[0] = mk(0, 1, 19'h5,    36'h7,         1, 19'h9,  0, 0, 19'h0,     36'h0,         1, 0, 0, 36'h0);
      vt[1] = mk(1, 0, 19'h0,    36'h0,         0, 19'h0,  0, 0, 19'h0,     36'h0,         1, 0, 0, 36'h0);
      vt[2] = mk(1, 1, 19'h00123, 36'h0ABCD1234, 0, 19'h0, 0, 0, 19'h0,     36'h0,         0, 0, 0, 36'h0);
      vt[3] = mk(1, 0, 19'h0,    36'h0,         0, 19'h0,  0, 0, 19'h0,     36'h0,         0, 1, 0, 36'h0);
      vt[4] = mk(1, 0, 19'h0,    36'h0,         0, 19'h0,  0, 1, 19'h00123, 36'h0ABCD1234, 1, 0, 0, 36'h0);
      vt[5] = mk(1, 0, 19'h0,    36'h0,         1, 19'h10, 1, 0, 19'h00123, 36'h0,         0, 0, 0, 36'h0);
      vt[6] = mk(1, 0, 19'h0,    36'h0,         0, 19'h0,  0, 0, 19'h10,    36'h0,         0, 0, 0, 36'h0);
      vt[7] = mk(1, 0, 19'h0,    36'h0,         0, 19'h0,  0, 0, 19'h10,    36'h0,         0, 0, 0, 36'h0);
      vt[8] = mk(1, 0, 19'h0,    36'h0,         0, 19'h0,  0, 0, 19'h10,    36'h0,         0, 0, 1, tag(19'h10));
      vt[9] = mk(1, 0, 19'h0,    36'h0,         0, 19'h0,  0, 0, 19'h10,    36'h0,         0, 0, 0, 36'h0);

      for (int i = 0; i < NV; i++) begin
         reset_n = vt[i].rst_n; bif.wr_req = vt[i].wr; bif.wr_addr = vt[i].wa;
         bif.wr_data = vt[i].wd; bif.rd_req = vt[i].rd; bif.rd_addr = vt[i].ra;
         @(negedge clk);
         chk($sformatf("row%0d_ack", i), bif.rd_ack, vt[i].e_ack);
         chk($sformatf("row%0d_we", i), bif.mem_we, vt[i].e_we);
         chk($sformatf("row%0d_addr", i), bif.mem_addr, vt[i].e_addr);
         chk($sformatf("row%0d_cnt", i), fifo_count, vt[i].e_cnt);
         chk($sformatf("row%0d_valid", i), bif.rd_valid, vt[i].e_valid);
         if (vt[i].chk_wd)  chk($sformatf("row%0d_wdata", i), bif.mem_wdata, vt[i].e_wd);
         if (vt[i].e_valid) chk($sformatf("row%0d_rdata", i), bif.rd_data, vt[i].e_rd);
         if (!vt[i].rst_n)  chk($sformatf("row%0d_ovf", i), wr_overflow, 1'b0);
         @(posedge clk);
         #1;
      end

      // Reads held high while six writes arrive: drain gives exactly four writes.
      hard_reset();
      bif.rd_req = 1; bif.rd_addr = 19'h200;
      for (int i = 0; i < 12; i++) begin
         bif.wr_req = (i < 6); bif.wr_addr = AW'(19'h100 + i); bif.wr_data = DW'($urandom());
         mstep(ack);
         ackv[i] = ack;
         if (ack) bif.rd_addr = AW'($urandom());
      end
      chk("prio_drain_ack_pattern", ackv, 12'b1100_0011_1111);
      bif.wr_req = 0; bif.rd_req = 0;
      for (int i = 0; i < 8; i++) mstep(ack);

      // Buffer held full with pops suppressed: the extra write is dropped.
      hard_reset();
      force dut.fifo_pop = 1'b0;
      nopop = 1;
      for (int i = 0; i < 9; i++) push_step(AW'(19'h300 + i));
      mstep(ack);
      mstep(ack);
      chk("ovf_sticky", wr_overflow, 1'b1);
      chk("ovf_count_full", fifo_count, 4'd8);

      // Same fill, but the ninth write coincides with a pop.
      hard_reset();
      for (int i = 0; i < 8; i++) push_step(AW'(19'h400 + i));
      release dut.fifo_pop;
      nopop = 0;
      push_step(19'h408);
      chk("full_push_pop_count", fifo_count, 4'd8);
      chk("full_push_pop_no_ovf", wr_overflow, 1'b0);
      for (int i = 0; i < 12; i++) mstep(ack);

      // Random traffic with a mid-operation reset, then logged ordering run.
      hard_reset();
      rand_drive(120, 19'h1000, 1);
      hard_reset();
      pushed.delete(); seen.delete(); n_ack = 0; n_valid = 0;
      log_en = 1;
      rand_drive(300, 19'h4000, 0);
      for (int i = 0; i < 30; i++) begin
         mstep(ack);
         if (ack) bif.rd_req = 0;
      end
      log_en = 0;
      chk("write_count", seen.size(), pushed.size());
      for (int i = 0; i < pushed.size() && i < seen.size(); i++)
         chk($sformatf("write_order%0d", i), seen[i], pushed[i]);
      chk("ack_valid_balance", n_valid, n_ack);
      chk("final_count", fifo_count, 4'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
